// File: rtl/reg_write_arbiter_pkg.sv
// Shared CPU constants for the register-file write arbiter: default widths and write-source indices.
package reg_write_arbiter_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int AW_DEF    = 3;

  localparam int SRC_ALU  = 0;
  localparam int SRC_LOAD = 1;
  localparam int SRC_IMM  = 2;
  localparam int SRC_LINK = 3;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational cyclic priority picker: first set req bit at or after ptr, wrapping at NREQ-1.
module rr_pick
  import reg_write_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      // explicit wrap so NREQ need not be a power of two
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = PW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port; registers the granted write
// into wr_en/wr_addr/wr_data one cycle after the grant.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  output logic [PW-1:0]         last_gnt
);

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_any;
  logic            xfer;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // the picker only selects requesting sources, so any grant is a transfer
  assign xfer = pick_any & ~rst & ~stall;
  assign gnt  = xfer ? pick_gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      last_gnt <= '0;
    end else if (xfer) begin
      wr_en    <= 1'b1;
      wr_addr  <= req_addr[pick_idx*AW +: AW];
      wr_data  <= req_data[pick_idx*WIDTH +: WIDTH];
      last_gnt <= pick_idx;
      ptr      <= (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + PW'(1);
    end else begin
      wr_en    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural round-robin model.
module tb_reg_write_arbiter;
  import reg_write_arbiter_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  stall;
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic [1:0]            last_gnt;

  reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .last_gnt (last_gnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int         m_ptr;
  bit         m_wr_en;
  logic [7:0] m_addr;
  logic [7:0] m_data;
  int         m_last;
  logic [7:0] regs [8];
  bit         pend [NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_wr_en = 0; m_addr = 0; m_data = 0; m_last = 0;
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req_addr[i*AW +: AW]       = a;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  // one cycle: check at negedge, advance model at posedge, return the granted index (-1 none)
  task automatic step(output int g);
    logic [NREQ-1:0] eg;
    @(negedge clk);
    g  = (rst || stall) ? -1 : pick(req);
    eg = (g < 0) ? '0 : NREQ'(1 << g);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("wr_en", 32'(wr_en), 32'(m_wr_en));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("wr_data", 32'(wr_data), 32'(m_data));
    chk("last_gnt", 32'(last_gnt), 32'(m_last));
    if (wr_en === 1'b1) regs[wr_addr] = wr_data;
    @(posedge clk);
    if (rst) model_reset();
    else if (g >= 0) begin
      m_wr_en = 1;
      m_addr  = 8'(req_addr[g*AW +: AW]);
      m_data  = req_data[g*WIDTH +: WIDTH];
      m_last  = g;
      m_ptr   = (g + 1) % NREQ;
    end else m_wr_en = 0;
    #1;
  endtask

  task automatic run(input logic [NREQ-1:0] r, input int n);
    int g;
    req = r;
    for (int c = 0; c < n; c++) step(g);
  endtask

  initial begin
    int g;
    rst = 1'b1; stall = 1'b0; req = '1; req_addr = '0; req_data = '0;
    model_reset();
    for (int i = 0; i < 8; i++) regs[i] = '0;
    for (int i = 0; i < NREQ; i++) set_src(i, AW'(i), WIDTH'(8'hA0 + i));
    @(posedge clk); #1;

    // reset held with all requests: no grants, outputs at reset values
    run(4'b1111, 2);
    rst = 1'b0;

    // round robin 0,1,2,3,0,1,2,3 then drain
    run(4'b1111, 8);
    run(4'b0000, 1);

    // ptr=3 after granting source 2, then skip/wrap on 4'b0101
    run(4'b0100, 1);
    chk("ptr_after_src2", 32'(m_ptr), 32'd3);
    run(4'b0101, 3);
    run(4'b0000, 1);

    // same-address collision from ptr=0
    rst = 1'b1; run(4'b0000, 1); rst = 1'b0;
    set_src(SRC_LOAD, 3'd5, 8'h11);
    set_src(SRC_IMM, 3'd5, 8'h22);
    run(4'b0110, 1);
    run(4'b0100, 1);
    run(4'b0000, 2);
    chk("reg5_final", 32'(regs[5]), 32'h22);

    // stall holds off a single request, then write lands one cycle after grant
    stall = 1'b1; run(4'b0010, 3);
    stall = 1'b0; run(4'b0010, 1);
    run(4'b0000, 1);

    // reset mid-stream with continuous traffic
    run(4'b1111, 3);
    rst = 1'b1; run(4'b1111, 1);
    rst = 1'b0; run(4'b1111, 2);
    run(4'b0000, 1);

    // randomized traffic obeying the hold-until-granted rule
    req = '0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            pend[i] = 1;
            req[i]  = 1'b1;
            set_src(i, AW'($urandom_range(0, 7)), WIDTH'($urandom_range(0, 255)));
          end else req[i] = 1'b0;
        end
      end
      step(g);
      if (g >= 0) pend[g] = 0;
    end
    rst = 1'b0; stall = 1'b0;
    run(4'b0000, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter that shares the single write port of the CPU register file among several write sources (ALU result, memory load, immediate/move, PC-link). Each source raises a request carrying a register address and data. The arbiter grants one source per cycle and drives a registered write strobe, address and data into the register bank's `we`/`d` inputs one cycle later. It sits between the execute-stage write sources and the register bank.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, minimum 2.
- `WIDTH`, 8: data width in bits.
- `AW`, 3: register address width, giving 2^AW registers.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `stall`, in, 1: when high, no grants are issued.
- `req`, in, NREQ: per-source write request.
- `req_addr`, in, NREQ*AW: packed destination addresses; source i is at [i*AW +: AW].
- `req_data`, in, NREQ*WIDTH: packed write data; source i is at [i*WIDTH +: WIDTH].
- `gnt`, out, NREQ: one-hot combinational grant. Transfer happens at the clock edge where `req[i] & gnt[i]`.
- `wr_en`, out, 1: registered write strobe to the register bank.
- `wr_addr`, out, AW: registered write address.
- `wr_data`, out, WIDTH: registered write data.
- `last_gnt`, out, clog2(NREQ): index of the most recently granted source, registered.

## Operation
- Internal state is the priority pointer `ptr` (0..NREQ-1). `ptr` marks the highest-priority source.
- Grant selection, combinational:
  - If `rst` or `stall` is high, or `req` is all zero, then `gnt` = 0.
  - Otherwise `gnt` is one-hot at the first set `req` bit, searching cyclically from `ptr` upward (`ptr`, `ptr+1`, … wrapping at NREQ-1 to 0).
- On an edge with a transfer from source i:
  - `wr_en` <= 1.
  - `wr_addr` <= `req_addr[i]`.
  - `wr_data` <= `req_data[i]`.
  - `last_gnt` <= i.
  - `ptr` <= (i+1) mod NREQ. The wrap is explicit, so NREQ need not be a power of 2.
- On an edge with no transfer:
  - `wr_en` <= 0.
  - `wr_addr`, `wr_data`, `last_gnt` and `ptr` hold their values.
- Requester rule: once `req[i]` is raised, it stays high with stable address and data until the edge where `gnt[i]` is seen. After that edge the source may drop `req` or present a new request.
- Writes to any address, including 0, pass through unmodified. Register-zero semantics belong to the register bank.
- Simultaneous requests to the same address are serialized in grant order. The later grant's data is the final register value.

## Timing
- Grant-to-write latency is 1 cycle. A transfer at edge N produces `wr_en`=1 during cycle N+1, and the register bank captures the data at edge N+1.
- Throughput is one write per cycle. Back-to-back grants to different or identical sources are allowed.
- Fairness: a held request is granted within NREQ cycles of `stall` being low.
- Reset values: `ptr`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `last_gnt`=0.
- Reset mid-operation:
  - `gnt` is forced to 0 during the reset cycle, so no transfer occurs.
  - A write already pending in `wr_en` is cleared at the reset edge.
  - Requesters holding `req` through reset are granted normally, starting from `ptr`=0, in the first cycle after `rst` falls.
- `stall` raised mid-stream:
  - The write already registered still completes in the next cycle.
  - No further grants are issued while `stall` is high, and `ptr` holds.

## Structure
- The shared CPU package holds the `WIDTH` and `AW` defaults and the source-index constants: `SRC_ALU`=0, `SRC_LOAD`=1, `SRC_IMM`=2, `SRC_LINK`=3.
- The combinational cyclic priority picker is one natural sub-module, `rr_pick`. Inputs are `req` and `ptr`; outputs are the one-hot grant, the grant index and an any-grant flag.
- The top level contains only the pointer register, the output registers and the stall/reset gating.

## Test plan
- **Reset:** hold `rst` with `req`=4'b1111. Require `gnt`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0. After `rst` falls, the first grant goes to source 0.
- **Round-robin:** hold `req`=4'b1111 for 8 cycles with source i driving addr=i, data=8'hA0+i.
  - Grants follow 0,1,2,3,0,1,2,3.
  - `wr_en` stays high continuously from the second cycle, with `wr_addr`/`wr_data` lagging the grant by 1 cycle.
- **Pointer skip and wrap:** `ptr`=3 (after granting source 2), then `req`=4'b0101. Require source 0 granted, then source 2, then source 0.
- **Same-address collision:**
  - Source 1 writes addr 5 data 8'h11 and source 2 writes addr 5 data 8'h22, both raised together from `ptr`=0.
  - Require the writes (5,8'h11) then (5,8'h22) on consecutive cycles, so the register ends at 8'h22.
- **Stall:**
  - `req`=4'b0010, with `stall` high for 3 cycles: `gnt`=0 and `wr_en`=0 throughout.
  - After `stall` drops: grant to source 1, and `wr_en` is high exactly one cycle later.
- **Reset mid-stream:** assert `rst` for 1 cycle during continuous 4'b1111 traffic. Require `wr_en`=0 in the following cycle, `ptr` back to 0, and the next grant to source 0.
